// File: rtl/motion_cmd_sched_pkg.sv
// Shared definitions for the motion command scheduler: valid command codes,
// source encodings and the one-hot scheduler state.
package motion_cmd_sched_pkg;

  localparam logic [7:0] CMD_MOVE_1 = 8'h01;
  localparam logic [7:0] CMD_MOVE_2 = 8'h02;
  localparam logic [7:0] CMD_MOVE_3 = 8'h03;
  localparam logic [7:0] CMD_MOVE_4 = 8'h04;
  localparam logic [7:0] CMD_TURN_1 = 8'h11;
  localparam logic [7:0] CMD_TURN_2 = 8'h12;
  localparam logic [7:0] CMD_TURN_3 = 8'h13;
  localparam logic [7:0] CMD_TURN_4 = 8'h14;
  localparam logic [7:0] CMD_SPD_1  = 8'h51;
  localparam logic [7:0] CMD_SPD_2  = 8'h52;
  localparam logic [7:0] CMD_AUX_1  = 8'h61;
  localparam logic [7:0] CMD_AUX_2  = 8'h62;

  localparam logic [7:0] STOP_CMD_DEFAULT = 8'h00;

  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_REMOTE = 2'd1;
  localparam logic [1:0] SRC_AUTO   = 2'd2;
  localparam logic [1:0] SRC_ESTOP  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_AUTO   = 4'b0010,
    ST_REMOTE = 4'b0100,
    ST_ESTOP  = 4'b1000
  } sched_state_e;

  function automatic logic isValidCmd(input logic [7:0] code);
    case (code)
      CMD_MOVE_1, CMD_MOVE_2, CMD_MOVE_3, CMD_MOVE_4,
      CMD_TURN_1, CMD_TURN_2, CMD_TURN_3, CMD_TURN_4,
      CMD_SPD_1, CMD_SPD_2, CMD_AUX_1, CMD_AUX_2: isValidCmd = 1'b1;
      default:                                     isValidCmd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/motion_cmd_sched_cycle_timer.sv
// Saturating cycle counter: clears on clr, counts on en, holds at limit.
// done is high while the count sits at limit.
module cycle_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != limit)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == limit);

endmodule

// File: rtl/motion_cmd_sched.sv
// Arbitrates remote link, autonomous planner and obstacle stop into one
// registered command stream with a link-loss watchdog and e-stop override.
module motion_cmd_sched
  import motion_cmd_sched_pkg::*;
#(
  parameter int         WDOG_CYCLES  = 50000000,
  parameter int         CLEAR_CYCLES = 5000000,
  parameter logic [7:0] STOP_CMD     = STOP_CMD_DEFAULT,
  parameter int         CNT_W        = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rem_valid,
  input  logic [7:0]  rem_cmd,
  input  logic [23:0] rem_arg,
  output logic        rem_ready,
  input  logic        auto_valid,
  input  logic [7:0]  auto_cmd,
  input  logic [23:0] auto_arg,
  output logic        auto_ready,
  input  logic        obs_stop,
  output logic [7:0]  cmd_out,
  output logic [23:0] arg_out,
  output logic        cmd_stb,
  output logic [1:0]  src_out,
  output logic        cmd_err
);

  localparam logic [CNT_W-1:0] WDOG_LIM  = CNT_W'(WDOG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LIM = CNT_W'(CLEAR_CYCLES - 1);

  sched_state_e state_q, state_d;
  logic [7:0]   cmd_q, cmd_d;
  logic [23:0]  arg_q, arg_d;
  logic [1:0]   src_q, src_d;
  logic         stb_q, stb_d;
  logic         err_q, err_d;

  logic remFire, autoFire, remOk, autoOk;
  logic wdogDone, clearDone;

  assign rem_ready  = (state_q != ST_ESTOP) && !obs_stop;
  assign auto_ready = ((state_q == ST_IDLE) || (state_q == ST_AUTO)) && !rem_valid && !obs_stop;

  assign remFire  = rem_valid && rem_ready;
  assign autoFire = auto_valid && auto_ready;
  assign remOk    = remFire && isValidCmd(rem_cmd);
  assign autoOk   = autoFire && isValidCmd(auto_cmd);

  // Watchdog only runs in REMOTE and restarts on every valid remote frame.
  cycle_timer #(.CNT_W(CNT_W)) u_wdog (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  ((state_q != ST_REMOTE) || remOk),
    .en   ((state_q == ST_REMOTE) && !remOk),
    .limit(WDOG_LIM),
    .done (wdogDone)
  );

  cycle_timer #(.CNT_W(CNT_W)) u_clear (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  ((state_q != ST_ESTOP) || obs_stop),
    .en   ((state_q == ST_ESTOP) && !obs_stop),
    .limit(CLEAR_LIM),
    .done (clearDone)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    arg_d   = arg_q;
    src_d   = src_q;
    stb_d   = 1'b0;
    err_d   = (remFire && !remOk) || (autoFire && !autoOk);
    if (obs_stop) begin
      if (state_q != ST_ESTOP) begin
        state_d = ST_ESTOP;
        cmd_d   = STOP_CMD;
        arg_d   = '0;
        src_d   = SRC_ESTOP;
        stb_d   = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE, ST_AUTO: begin
          if (remOk) begin
            state_d = ST_REMOTE;
            cmd_d   = rem_cmd;
            arg_d   = rem_arg;
            src_d   = SRC_REMOTE;
            stb_d   = 1'b1;
          end else if (autoOk) begin
            state_d = ST_AUTO;
            cmd_d   = auto_cmd;
            arg_d   = auto_arg;
            src_d   = SRC_AUTO;
            stb_d   = 1'b1;
          end
        end
        ST_REMOTE: begin
          if (remOk) begin
            cmd_d = rem_cmd;
            arg_d = rem_arg;
            stb_d = 1'b1;
          end else if (wdogDone) begin
            state_d = ST_IDLE;
            cmd_d   = STOP_CMD;
            arg_d   = '0;
            src_d   = SRC_NONE;
            stb_d   = 1'b1;
          end
        end
        ST_ESTOP: begin
          if (clearDone) begin
            state_d = ST_IDLE;
            src_d   = SRC_NONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= STOP_CMD;
      arg_q   <= '0;
      src_q   <= SRC_NONE;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      arg_q   <= arg_d;
      src_q   <= src_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
    end
  end

  assign cmd_out = cmd_q;
  assign arg_out = arg_q;
  assign src_out = src_q;
  assign cmd_stb = stb_q;
  assign cmd_err = err_q;

endmodule

// File: tb/tb_motion_cmd_sched.sv
// Directed bench for motion_cmd_sched with a short watchdog (8) and
// e-stop clear window (4); expected values are hand-derived.
module tb_motion_cmd_sched;

  logic        clk;
  logic        rst_n;
  logic        rem_valid;
  logic [7:0]  rem_cmd;
  logic [23:0] rem_arg;
  logic        rem_ready;
  logic        auto_valid;
  logic [7:0]  auto_cmd;
  logic [23:0] auto_arg;
  logic        auto_ready;
  logic        obs_stop;
  logic [7:0]  cmd_out;
  logic [23:0] arg_out;
  logic        cmd_stb;
  logic [1:0]  src_out;
  logic        cmd_err;

  int checks = 0;
  int errors = 0;

  motion_cmd_sched #(
    .WDOG_CYCLES (8),
    .CLEAR_CYCLES(4),
    .STOP_CMD    (8'h00),
    .CNT_W       (26)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rem_valid (rem_valid),
    .rem_cmd   (rem_cmd),
    .rem_arg   (rem_arg),
    .rem_ready (rem_ready),
    .auto_valid(auto_valid),
    .auto_cmd  (auto_cmd),
    .auto_arg  (auto_arg),
    .auto_ready(auto_ready),
    .obs_stop  (obs_stop),
    .cmd_out   (cmd_out),
    .arg_out   (arg_out),
    .cmd_stb   (cmd_stb),
    .src_out   (src_out),
    .cmd_err   (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 ns past it before sampling or driving.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; rem_valid = 1'b0; rem_cmd = '0; rem_arg = '0;
    auto_valid = 1'b0; auto_cmd = '0; auto_arg = '0; obs_stop = 1'b0;
    #12 rst_n = 1'b1;
    #1;
    checkOutput("rst_cmd", 32'(cmd_out), 32'h00);
    checkOutput("rst_arg", 32'(arg_out), 32'h0);
    checkOutput("rst_src", 32'(src_out), 32'd0);
    checkOutput("rst_stb", 32'(cmd_stb), 32'd0);
    checkOutput("rst_err", 32'(cmd_err), 32'd0);
    checkOutput("rst_rem_ready", 32'(rem_ready), 32'd1);
    checkOutput("rst_auto_ready", 32'(auto_ready), 32'd1);

    $display("[TB] remote frame then watchdog expiry");
    rem_valid = 1'b1; rem_cmd = 8'h01; rem_arg = 24'h123456;
    #1 checkOutput("rem_ready_idle", 32'(rem_ready), 32'd1);
    applyStimulus(1);
    rem_valid = 1'b0;
    checkOutput("rem_cmd", 32'(cmd_out), 32'h01);
    checkOutput("rem_arg", 32'(arg_out), 32'h123456);
    checkOutput("rem_src", 32'(src_out), 32'd1);
    checkOutput("rem_stb", 32'(cmd_stb), 32'd1);
    #1 checkOutput("auto_ready_remote", 32'(auto_ready), 32'd0);
    applyStimulus(1);
    checkOutput("rem_stb_drop", 32'(cmd_stb), 32'd0);
    applyStimulus(6);
    checkOutput("wdog_pre_cmd", 32'(cmd_out), 32'h01);
    checkOutput("wdog_pre_src", 32'(src_out), 32'd1);
    applyStimulus(1);
    checkOutput("wdog_cmd", 32'(cmd_out), 32'h00);
    checkOutput("wdog_arg", 32'(arg_out), 32'h0);
    checkOutput("wdog_stb", 32'(cmd_stb), 32'd1);
    checkOutput("wdog_src", 32'(src_out), 32'd0);
    applyStimulus(1);
    checkOutput("wdog_stb_drop", 32'(cmd_stb), 32'd0);

    $display("[TB] simultaneous remote and auto requests");
    rem_valid = 1'b1; rem_cmd = 8'h11; rem_arg = 24'h0000AA;
    auto_valid = 1'b1; auto_cmd = 8'h51; auto_arg = 24'h000BBB;
    #1 checkOutput("both_auto_ready", 32'(auto_ready), 32'd0);
    applyStimulus(1);
    rem_valid = 1'b0;
    #1;
    checkOutput("both_cmd", 32'(cmd_out), 32'h11);
    checkOutput("both_src", 32'(src_out), 32'd1);
    checkOutput("held_auto_ready", 32'(auto_ready), 32'd0);
    applyStimulus(7);
    checkOutput("held_cmd", 32'(cmd_out), 32'h11);
    applyStimulus(1);
    checkOutput("held_wdog_cmd", 32'(cmd_out), 32'h00);
    checkOutput("held_wdog_src", 32'(src_out), 32'd0);
    checkOutput("held_auto_ready_idle", 32'(auto_ready), 32'd1);
    applyStimulus(1);
    checkOutput("auto_cmd", 32'(cmd_out), 32'h51);
    checkOutput("auto_arg", 32'(arg_out), 32'h000BBB);
    checkOutput("auto_src", 32'(src_out), 32'd2);
    checkOutput("auto_stb", 32'(cmd_stb), 32'd1);

    $display("[TB] obstacle stop from AUTO");
    auto_cmd = 8'h61; auto_arg = 24'h00CAFE;
    applyStimulus(1);
    auto_valid = 1'b0;
    checkOutput("auto61_cmd", 32'(cmd_out), 32'h61);
    obs_stop = 1'b1;
    #1;
    checkOutput("obs_rem_ready", 32'(rem_ready), 32'd0);
    checkOutput("obs_auto_ready", 32'(auto_ready), 32'd0);
    applyStimulus(1);
    checkOutput("estop_cmd", 32'(cmd_out), 32'h00);
    checkOutput("estop_arg", 32'(arg_out), 32'h0);
    checkOutput("estop_src", 32'(src_out), 32'd3);
    checkOutput("estop_stb", 32'(cmd_stb), 32'd1);
    applyStimulus(1);
    checkOutput("estop_stb_once", 32'(cmd_stb), 32'd0);
    obs_stop = 1'b0;
    #1 checkOutput("estop_rem_ready", 32'(rem_ready), 32'd0);
    applyStimulus(3);
    checkOutput("estop_hold3_src", 32'(src_out), 32'd3);
    obs_stop = 1'b1;
    applyStimulus(1);
    checkOutput("estop_pulse_src", 32'(src_out), 32'd3);
    obs_stop = 1'b0;
    applyStimulus(3);
    checkOutput("estop_low3_src", 32'(src_out), 32'd3);
    applyStimulus(1);
    checkOutput("clear_src", 32'(src_out), 32'd0);
    checkOutput("clear_stb", 32'(cmd_stb), 32'd0);
    checkOutput("clear_cmd", 32'(cmd_out), 32'h00);

    $display("[TB] invalid remote code");
    rem_valid = 1'b1; rem_cmd = 8'h7F; rem_arg = 24'h555555;
    #1 checkOutput("bad_rem_ready", 32'(rem_ready), 32'd1);
    applyStimulus(1);
    rem_valid = 1'b0;
    checkOutput("bad_err", 32'(cmd_err), 32'd1);
    checkOutput("bad_stb", 32'(cmd_stb), 32'd0);
    checkOutput("bad_cmd", 32'(cmd_out), 32'h00);
    checkOutput("bad_src", 32'(src_out), 32'd0);
    applyStimulus(1);
    checkOutput("bad_err_drop", 32'(cmd_err), 32'd0);

    $display("[TB] asynchronous reset mid-REMOTE");
    rem_valid = 1'b1; rem_cmd = 8'h02; rem_arg = 24'h000777;
    applyStimulus(1);
    rem_valid = 1'b0;
    checkOutput("pre_rst_src", 32'(src_out), 32'd1);
    checkOutput("pre_rst_stb", 32'(cmd_stb), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_cmd", 32'(cmd_out), 32'h00);
    checkOutput("async_rst_arg", 32'(arg_out), 32'h0);
    checkOutput("async_rst_src", 32'(src_out), 32'd0);
    checkOutput("async_rst_stb", 32'(cmd_stb), 32'd0);
    #10 rst_n = 1'b1;
    applyStimulus(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
